// File: rtl/pwm_peripheral.sv
// pwm_peripheral: multi-channel PWM generator driven by the SPI register block.
// A clock prescaler and an 8-bit period counter (0..254) set the PWM frequency.
// Every channel compares the period counter against a shared active duty value.
// period_start pulses for one clk after each period wrap.
// Optional feature macro: PWM_SYNC_UPDATE_EN. When it is defined, the active duty
// is reloaded only at the period wrap, so changes are glitch-free. When it is
// undefined, the active duty follows the duty input every clk.
module pwm_peripheral #(
   parameter int unsigned NUM_CH   = 8,
   parameter int unsigned PRESCALE = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NUM_CH-1:0] out_en,
   input  logic [NUM_CH-1:0] pwm_en,
   input  logic [7:0]        duty,
   output logic [NUM_CH-1:0] pwm_out,
   output logic              period_start
);

   localparam int unsigned PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int unsigned CNT_W = 8;

   localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(PRESCALE - 1);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(254);
   localparam logic [CNT_W-1:0] DUTY_FULL = CNT_W'(255);

   logic [PRE_W-1:0]  pre_cnt;
   logic [CNT_W-1:0]  pwm_cnt;
   logic [CNT_W-1:0]  duty_act;
   logic              tick_c;
   logic              wrap_c;
   logic              pwm_hi_c;
   logic [NUM_CH-1:0] next_out_c;

   // Tick and wrap strobes decoded from the current counter values
   always_comb begin
      tick_c   = 1'b0;
      wrap_c   = 1'b0;
      pwm_hi_c = 1'b0;
      tick_c   = (pre_cnt == PRE_LAST);
      wrap_c   = tick_c && (pwm_cnt == CNT_LAST);
      pwm_hi_c = (duty_act == DUTY_FULL) || (pwm_cnt < duty_act);
   end

   // Prescaler: counts 0..PRESCALE-1 and wraps on each tick
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pre_cnt <= '0;
      end else if (tick_c) begin
         pre_cnt <= '0;
      end else begin
         pre_cnt <= pre_cnt + PRE_W'(1);
      end
   end

   // Period counter: advances on tick, runs 0..254 and wraps
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pwm_cnt <= '0;
      end else if (wrap_c) begin
         pwm_cnt <= '0;
      end else if (tick_c) begin
         pwm_cnt <= pwm_cnt + CNT_W'(1);
      end
   end

   // Period start strobe: one clk high right after the wrap edge
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         period_start <= 1'b0;
      end else begin
         period_start <= wrap_c;
      end
   end

`ifdef PWM_SYNC_UPDATE_EN
   // Active duty is reloaded only at the wrap, so the running period completes unchanged
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         duty_act <= '0;
      end else if (wrap_c) begin
         duty_act <= duty;
      end
   end
`else
   // Active duty follows the register every clk; runt or stretched pulses are allowed
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         duty_act <= '0;
      end else begin
         duty_act <= duty;
      end
   end
`endif

   // Per-channel output select: disabled -> 0, static mode -> 1, PWM mode -> compare
   always_comb begin
      next_out_c = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (!out_en[i]) begin
            next_out_c[i] = 1'b0;
         end else if (!pwm_en[i]) begin
            next_out_c[i] = 1'b1;
         end else begin
            next_out_c[i] = pwm_hi_c;
         end
      end
   end

   // Output pins are registered
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pwm_out <= '0;
      end else begin
         pwm_out <= next_out_c;
      end
   end

endmodule

// File: tb/tb_pwm_peripheral.sv
// tb_pwm_peripheral: directed bench for pwm_peripheral at its default parameters
// (NUM_CH=8, PRESCALE=10, so one period lasts 2550 clks).
module tb_pwm_peripheral;

   localparam int unsigned NUM_CH = 8;
   localparam int          PER    = 2550;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NUM_CH-1:0] out_en;
   logic [NUM_CH-1:0] pwm_en;
   logic [7:0]        duty;
   logic [NUM_CH-1:0] pwm_out;
   logic              period_start;

   int   total = 0;
   int   bad   = 0;
   int   hi [NUM_CH];
   int   ps_cnt;
   logic last_ps;
   int   n;

   pwm_peripheral dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .out_en       (out_en),
      .pwm_en       (pwm_en),
      .duty         (duty),
      .pwm_out      (pwm_out),
      .period_start (period_start)
   );

   always #5 clk = ~clk;

   // Advance one clk and settle just after the rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic clear_meas();
      for (int i = 0; i < NUM_CH; i++) hi[i] = 0;
      ps_cnt  = 0;
      last_ps = 1'b0;
   endtask

   // Sample outputs for a number of clks, accumulating high counts per pin
   task automatic meas(input int cycles);
      for (int k = 0; k < cycles; k++) begin
         step();
         for (int i = 0; i < NUM_CH; i++)
            if (pwm_out[i] === 1'b1) hi[i]++;
         if (period_start === 1'b1) ps_cnt++;
         last_ps = period_start;
      end
   endtask

   // Wait (bounded) for the next period_start pulse; report clks taken
   task automatic wait_ps(output int steps);
      steps = 0;
      do begin
         step();
         steps++;
      end while (period_start !== 1'b1 && steps < 2 * PER);
      chk("wait_period_start", 32'(period_start), 32'd1);
   endtask

   initial begin
      rst_n  = 1'b0;
      out_en = '0;
      pwm_en = '0;
      duty   = 8'h00;

      // 1: reset state, then a single static-high channel
      step(); step(); step();
      chk("reset_pwm_out", 32'(pwm_out), 32'h00);
      chk("reset_period_start", 32'(period_start), 32'd0);
      rst_n  = 1'b1;
      out_en = 8'h01;
      step();
      chk("static_ch0_1clk", 32'(pwm_out), 32'h01);
      for (int k = 0; k < 5; k++) step();
      chk("static_ch0_hold", 32'(pwm_out), 32'h01);

      // 2: all channels PWM at duty 0x80
      out_en = 8'hFF;
      pwm_en = 8'hFF;
      duty   = 8'h80;
      wait_ps(n);
      clear_meas();
      meas(PER);
      chk("d80_hi_ch0", 32'(hi[0]), 32'd1280);
      chk("d80_hi_ch3", 32'(hi[3]), 32'd1280);
      chk("d80_hi_ch7", 32'(hi[7]), 32'd1280);
      chk("d80_ps_count", 32'(ps_cnt), 32'd1);
      chk("d80_ps_at_end", 32'(last_ps), 32'd1);

      // 3: duty 0x00 never high over three periods, duty 0xFF always high
      duty = 8'h00;
      wait_ps(n);
      clear_meas();
      meas(3 * PER);
      chk("d00_hi_ch0", 32'(hi[0]), 32'd0);
      chk("d00_hi_ch7", 32'(hi[7]), 32'd0);
      chk("d00_ps_count", 32'(ps_cnt), 32'd3);
      duty = 8'hFF;
      wait_ps(n);
      clear_meas();
      meas(PER);
      chk("dff_hi_ch0", 32'(hi[0]), 32'd2550);
      chk("dff_hi_ch7", 32'(hi[7]), 32'd2550);

      // 4: duty 0x40 -> 0xC0 halfway through a period
      duty = 8'h40;
      wait_ps(n);
      clear_meas();
      meas(PER / 2);
      duty = 8'hC0;
      meas(PER / 2);
`ifdef PWM_SYNC_UPDATE_EN
      chk("mid_change_cur_period", 32'(hi[0]), 32'd640);
`else
      chk("mid_change_cur_period", 32'(hi[0]), 32'd1284);
`endif
      chk("mid_change_ps_at_end", 32'(last_ps), 32'd1);
      clear_meas();
      meas(PER);
      chk("mid_change_next_ch0", 32'(hi[0]), 32'd1920);
      chk("mid_change_next_ch7", 32'(hi[7]), 32'd1920);

      // 5: reset held low 3 clks mid-period
      for (int k = 0; k < 1000; k++) step();
      rst_n = 1'b0;
      step();
      chk("midrst_pwm_out_first", 32'(pwm_out), 32'h00);
      chk("midrst_ps_first", 32'(period_start), 32'd0);
      step(); step();
      chk("midrst_pwm_out_hold", 32'(pwm_out), 32'h00);
      rst_n = 1'b1;
      wait_ps(n);
      chk("midrst_first_ps_delay", 32'(n), 32'd2550);

      // 6: mixed enables
      out_en = 8'h0F;
      pwm_en = 8'h05;
      duty   = 8'h80;
      wait_ps(n);
      clear_meas();
      meas(PER);
      chk("mix_ch0_pwm", 32'(hi[0]), 32'd1280);
      chk("mix_ch1_static", 32'(hi[1]), 32'd2550);
      chk("mix_ch2_pwm", 32'(hi[2]), 32'd1280);
      chk("mix_ch3_static", 32'(hi[3]), 32'd2550);
      chk("mix_ch4_off", 32'(hi[4]), 32'd0);
      chk("mix_ch7_off", 32'(hi[7]), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
